vram_arbiter: RTL

- Shares the single-port 128 KB video RAM among four requesters: CPU/register interface, sprite renderer, layer 1 renderer and layer 2 renderer.
- The CPU has priority, but an anti-starvation counter keeps the line renderers fed so they finish within a display line.
- The renderers rotate round-robin among themselves.
- Read data returns one cycle after a grant and is tagged to its requester.

---
 rtl/vram_arb_pkg.sv | 26 ++
 rtl/vram_arbiter_rr_pick3.sv | 33 +++
 rtl/vram_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared types and constants for the VRAM arbiter
package vram_arb_pkg;

  typedef enum logic [2:0] {
    REQ_CPU  = 3'd0,
    REQ_SPR  = 3'd1,
    REQ_L1   = 3'd2,
    REQ_L2   = 3'd3,
    REQ_NONE = 3'd4
  } req_e;

  localparam int unsigned VRAM_ADDR_W = 15;
  localparam int unsigned VRAM_DATA_W = 32;
  localparam int unsigned NUM_REQ     = 4;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Bit n of the result belongs to requester code n; REQ_NONE maps to all zeros.
  function automatic req_vec_t req_onehot(req_e r);
    req_vec_t v;
    v = '0;
    if (r != REQ_NONE) v[r[1:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_pick3.sv
// rtl/vram_arbiter_rr_pick3.sv - combinational 3-way round-robin picker
module rr_pick3 (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] gnt_o,
  output logic       valid_o
);

  assign valid_o = |req_i;

  // Search order starts at ptr_i and wraps; bit 0 = SPR, 1 = L1, 2 = L2.
  always_comb begin
    gnt_o = 3'b000;
    case (ptr_i)
      2'd1: begin
        if      (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      2'd2: begin
        if      (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - CPU-priority VRAM arbiter with round-robin renderers and anti-starvation
// Optional per-renderer stall counters are built when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W        = VRAM_ADDR_W,
  parameter int DATA_W        = VRAM_DATA_W,
  parameter int CPU_BURST_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wrdata,
  input  logic [3:0]        cpu_wrbytesel,
  output logic              cpu_ack,
  output logic              cpu_rddata_valid,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_ack,
  output logic              spr_rddata_valid,
  input  logic              l1_req,
  input  logic [ADDR_W-1:0] l1_addr,
  output logic              l1_ack,
  output logic              l1_rddata_valid,
  input  logic              l2_req,
  input  logic [ADDR_W-1:0] l2_addr,
  output logic              l2_ack,
  output logic              l2_rddata_valid,
  output logic [DATA_W-1:0] rddata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wrdata,
  output logic [3:0]        vram_wrbytesel,
  output logic              vram_write,
  input  logic [DATA_W-1:0] vram_rddata
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       spr_stall_cnt,
  output logic [15:0]       l1_stall_cnt,
  output logic [15:0]       l2_stall_cnt
`endif
);

  localparam int SW = $clog2(CPU_BURST_MAX + 1);
  localparam logic [SW-1:0] BURST_MAX = SW'(CPU_BURST_MAX);

  req_e              gnt_q, gnt_d, rd_tag_q;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic [3:0]        be_q, be_d;
  logic              write_q, write_d;

  logic [2:0] rend_req, pick;
  logic       rend_any, pick_valid, cpu_win;
  req_vec_t   ack_vec, rd_vec;

  assign rend_req = {l2_req, l1_req, spr_req};
  assign rend_any = |rend_req;
  assign cpu_win  = cpu_req && (!rend_any || (streak_q < BURST_MAX));

  rr_pick3 u_pick (
    .req_i   (rend_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick),
    .valid_o (pick_valid)
  );

  always_comb begin
    gnt_d    = REQ_NONE;
    rr_ptr_d = rr_ptr_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    be_d     = 4'b0000;
    write_d  = 1'b0;
    if (cpu_win) begin
      gnt_d  = REQ_CPU;
      addr_d = cpu_addr;
      if (cpu_write) begin
        write_d  = 1'b1;
        be_d     = cpu_wrbytesel;
        wrdata_d = cpu_wrdata;
      end
      // cpu_win with a renderer pending implies streak_q < BURST_MAX, so this saturates.
      if (rend_any) streak_d = streak_q + 1'b1;
    end else if (pick_valid) begin
      streak_d = '0;
      case (pick)
        3'b001: begin gnt_d = REQ_SPR; addr_d = spr_addr; rr_ptr_d = 2'd1; end
        3'b010: begin gnt_d = REQ_L1;  addr_d = l1_addr;  rr_ptr_d = 2'd2; end
        default: begin gnt_d = REQ_L2; addr_d = l2_addr;  rr_ptr_d = 2'd0; end
      endcase
    end
    if (!rend_any) streak_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q    <= REQ_NONE;
      rd_tag_q <= REQ_NONE;
      rr_ptr_q <= 2'd0;
      streak_q <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      be_q     <= 4'b0000;
      write_q  <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      rd_tag_q <= (gnt_q != REQ_NONE && !write_q) ? gnt_q : REQ_NONE;
      rr_ptr_q <= rr_ptr_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      be_q     <= be_d;
      write_q  <= write_d;
    end
  end

  // Gating with rst drops a read return that lands while reset is being applied.
  assign ack_vec = req_onehot(gnt_q);
  assign rd_vec  = rst ? req_onehot(rd_tag_q) : '0;

  assign cpu_ack          = ack_vec[0];
  assign spr_ack          = ack_vec[1];
  assign l1_ack           = ack_vec[2];
  assign l2_ack           = ack_vec[3];
  assign cpu_rddata_valid = rd_vec[0];
  assign spr_rddata_valid = rd_vec[1];
  assign l1_rddata_valid  = rd_vec[2];
  assign l2_rddata_valid  = rd_vec[3];
  assign rddata           = (|rd_vec) ? vram_rddata : '0;

  assign vram_addr      = addr_q;
  assign vram_wrdata    = wrdata_q;
  assign vram_wrbytesel = be_q;
  assign vram_write     = write_q;

`ifdef VRAM_ARB_STATS_EN
  logic [2:0]  rend_ack;
  logic [15:0] stall_q [3];

  assign rend_ack = {l2_ack, l1_ack, spr_ack};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst || stats_clr) begin
        stall_q[i] <= 16'd0;
      end else if (rend_req[i] && !rend_ack[i] && stall_q[i] != 16'hFFFF) begin
        stall_q[i] <= stall_q[i] + 16'd1;
      end
    end
  end

  assign spr_stall_cnt = stall_q[0];
  assign l1_stall_cnt  = stall_q[1];
  assign l2_stall_cnt  = stall_q[2];
`endif

endmodule
